// File: rtl/mip_pkg.sv
// Shared types and default widths for the mass-interaction pipeline.
package mip_pkg;

    localparam int MIP_SIZE       = 27;
    localparam int MIP_ADDR_WIDTH = 4;
    localparam int MIP_LINK_WIDTH = 4;

    typedef logic signed [MIP_SIZE-1:0] mass_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/link_fetch_sequencer_if.sv
// Output beat of the link fetch sequencer: one link's two mass states per valid/ready transfer.
interface link_fetch_sequencer_if #(
    parameter int SIZE       = 27,
    parameter int LINK_WIDTH = 4
);
    logic                   out_valid;
    logic                   out_ready;
    logic signed [SIZE-1:0] out_p1;
    logic signed [SIZE-1:0] out_p2;
    logic [LINK_WIDTH-1:0]  out_link;

    modport master (
        output out_valid,
        output out_p1,
        output out_p2,
        output out_link,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_p1,
        input  out_p2,
        input  out_link,
        output out_ready
    );
endinterface

// File: rtl/link_fetch_stage.sv
// Output register capturing the mass-RAM read data for one link.
// LINK_FETCH_FWD_EN: substitute a same-cycle RAM write for the stale read data.
module link_fetch_stage #(
    parameter int SIZE       = 27,
    parameter int ADDR_WIDTH = 4,
    parameter int LINK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   adv_i,
    input  logic                   v_i,
    input  logic [LINK_WIDTH-1:0]  link_i,
    input  logic [ADDR_WIDTH-1:0]  r_addr1_i,
    input  logic [ADDR_WIDTH-1:0]  r_addr2_i,
    input  logic signed [SIZE-1:0] q1_i,
    input  logic signed [SIZE-1:0] q2_i,
    input  logic                   snoop_we_i,
    input  logic [ADDR_WIDTH-1:0]  snoop_w_addr_i,
    input  logic signed [SIZE-1:0] snoop_d_i,
    output logic                   valid_o,
    output logic signed [SIZE-1:0] p1_o,
    output logic signed [SIZE-1:0] p2_o,
    output logic [LINK_WIDTH-1:0]  link_o
);

    logic                   valid_q;
    logic signed [SIZE-1:0] p1_q, p1_d;
    logic signed [SIZE-1:0] p2_q, p2_d;
    logic [LINK_WIDTH-1:0]  link_q;

    always_comb begin
        p1_d = q1_i;
        p2_d = q2_i;
`ifdef LINK_FETCH_FWD_EN
        if (snoop_we_i && (snoop_w_addr_i == r_addr1_i)) p1_d = snoop_d_i;
        if (snoop_we_i && (snoop_w_addr_i == r_addr2_i)) p2_d = snoop_d_i;
`endif
    end

`ifndef LINK_FETCH_FWD_EN
    logic unused_snoop;
    assign unused_snoop = ^{snoop_we_i, snoop_w_addr_i, snoop_d_i, r_addr1_i, r_addr2_i};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            p1_q    <= '0;
            p2_q    <= '0;
            link_q  <= '0;
        end else if (adv_i) begin
            valid_q <= v_i;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            link_q  <= link_i;
        end
    end

    assign valid_o = valid_q;
    assign p1_o    = p1_q;
    assign p2_o    = p2_q;
    assign link_o  = link_q;

endmodule

// File: rtl/link_fetch_sequencer.sv
// Walks the link table for one frame and streams each link's two mass states downstream.
// LINK_FETCH_FWD_EN enables write-snoop forwarding in the output stage.
module link_fetch_sequencer
    import mip_pkg::*;
#(
    parameter int SIZE       = MIP_SIZE,
    parameter int ADDR_WIDTH = MIP_ADDR_WIDTH,
    parameter int LINK_WIDTH = MIP_LINK_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LINK_WIDTH:0]    num_links,
    output logic [LINK_WIDTH-1:0]  link_addr,
    input  logic [ADDR_WIDTH-1:0]  link_m1,
    input  logic [ADDR_WIDTH-1:0]  link_m2,
    output logic [ADDR_WIDTH-1:0]  r_addr_q1,
    output logic [ADDR_WIDTH-1:0]  r_addr_q2,
    input  logic signed [SIZE-1:0] q1,
    input  logic signed [SIZE-1:0] q2,
    input  logic                   snoop_we,
    input  logic [ADDR_WIDTH-1:0]  snoop_w_addr,
    input  logic signed [SIZE-1:0] snoop_d,
    output logic                   busy,
    output logic                   done,
    link_fetch_sequencer_if.master out_if
);

    localparam logic [LINK_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [LINK_WIDTH-1:0] LINK_ONE = 1;

    fetch_state_e          state_q, state_d;
    logic [LINK_WIDTH:0]   count_q, count_d;
    logic [LINK_WIDTH-1:0] link_addr_q, link_addr_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] s1_m1_q, s1_m2_q;
    logic [LINK_WIDTH-1:0] s1_link_q;
    logic                  s1_v_q;

    logic                  out_valid;
    logic                  adv;
    logic [LINK_WIDTH:0]   last_idx;

    // The whole pipe stalls as one unit whenever a beat is held downstream.
    assign adv      = !out_valid || out_if.out_ready;
    assign last_idx = count_q - CNT_ONE;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        link_addr_d = link_addr_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_links != '0) begin
                        count_d     = num_links;
                        link_addr_d = '0;
                        state_d     = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (adv) begin
                    if ({1'b0, link_addr_q} == last_idx) state_d = DRAIN;
                    else                                link_addr_d = link_addr_q + LINK_ONE;
                end
            end
            DRAIN: begin
                // S1 empty and the output register either empty or handing off now.
                if (!s1_v_q && adv) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            link_addr_q <= '0;
            done_q      <= 1'b0;
            s1_m1_q     <= '0;
            s1_m2_q     <= '0;
            s1_link_q   <= '0;
            s1_v_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            link_addr_q <= link_addr_d;
            done_q      <= done_d;
            if (adv) begin
                s1_m1_q   <= link_m1;
                s1_m2_q   <= link_m2;
                s1_link_q <= link_addr_q;
                s1_v_q    <= (state_q == ISSUE);
            end
        end
    end

    assign link_addr = link_addr_q;
    assign r_addr_q1 = s1_m1_q;
    assign r_addr_q2 = s1_m2_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    logic signed [SIZE-1:0] p1, p2;
    logic [LINK_WIDTH-1:0]  link_out;

    link_fetch_stage #(
        .SIZE       (SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINK_WIDTH (LINK_WIDTH)
    ) u_stage (
        .clk            (clk),
        .reset          (reset),
        .adv_i          (adv),
        .v_i            (s1_v_q),
        .link_i         (s1_link_q),
        .r_addr1_i      (s1_m1_q),
        .r_addr2_i      (s1_m2_q),
        .q1_i           (q1),
        .q2_i           (q2),
        .snoop_we_i     (snoop_we),
        .snoop_w_addr_i (snoop_w_addr),
        .snoop_d_i      (snoop_d),
        .valid_o        (out_valid),
        .p1_o           (p1),
        .p2_o           (p2),
        .link_o         (link_out)
    );

    assign out_if.out_valid = out_valid;
    assign out_if.out_p1    = p1;
    assign out_if.out_p2    = p2;
    assign out_if.out_link  = link_out;

endmodule

// File: tb/tb_link_fetch_sequencer.sv
// Directed bench for link_fetch_sequencer with a beat scoreboard and combinational RAM/link-table models.
module tb_link_fetch_sequencer;
    import mip_pkg::*;

    typedef struct {
        mass_word_t p1;
        mass_word_t p2;
        logic [3:0] link;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] num_links;
    logic [3:0] link_addr, link_m1, link_m2;
    logic [3:0] r_addr_q1, r_addr_q2;
    mass_word_t q1, q2;
    logic       snoop_we;
    logic [3:0] snoop_w_addr;
    mass_word_t snoop_d;
    logic       busy, done;

    link_fetch_sequencer_if #(.SIZE(27), .LINK_WIDTH(4)) beat_if ();

    link_fetch_sequencer #(.SIZE(27), .ADDR_WIDTH(4), .LINK_WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_links    (num_links),
        .link_addr    (link_addr),
        .link_m1      (link_m1),
        .link_m2      (link_m2),
        .r_addr_q1    (r_addr_q1),
        .r_addr_q2    (r_addr_q2),
        .q1           (q1),
        .q2           (q2),
        .snoop_we     (snoop_we),
        .snoop_w_addr (snoop_w_addr),
        .snoop_d      (snoop_d),
        .busy         (busy),
        .done         (done),
        .out_if       (beat_if.master)
    );

    always #5 clk = ~clk;

    mass_word_t mem [16];
    logic [3:0] tbl_m1 [16];
    logic [3:0] tbl_m2 [16];
    assign q1      = mem[r_addr_q1];
    assign q2      = mem[r_addr_q2];
    assign link_m1 = tbl_m1[link_addr];
    assign link_m2 = tbl_m2[link_addr];

    beat_t exp_q [$];
    beat_t mon_e;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    last_hs_cyc = 0;
    int    start_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: any visible beat must match the oldest pending expectation.
    always @(negedge clk) begin
        if (beat_if.out_valid === 1'b1) begin
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q[0];
                chk("out_p1", beat_if.out_p1, mon_e.p1);
                chk("out_p2", beat_if.out_p2, mon_e.p2);
                chk("out_link", beat_if.out_link, mon_e.link);
                if (beat_if.out_ready) begin
                    void'(exp_q.pop_front());
                    last_hs_cyc = cyc;
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", busy, 0);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_link(input int i, input int a, input int b);
        beat_t e;
        tbl_m1[i] = 4'(a);
        tbl_m2[i] = 4'(b);
        e.p1   = mass_word_t'(100 + a);
        e.p2   = mass_word_t'(100 + b);
        e.link = 4'(i);
        exp_q.push_back(e);
    endtask

    task automatic std_frame;
        set_link(0, 0, 1);
        set_link(1, 2, 3);
        set_link(2, 5, 5);
    endtask

    task automatic pulse_start(input int n);
        num_links = 5'(n);
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != base) break;
            step();
        end
        chk("done_seen", done_cnt - base, 1);
    endtask

    task automatic wait_beat(input int l);
        int found;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (beat_if.out_valid === 1'b1 && beat_if.out_link == 4'(l)) begin
                found = 1;
                break;
            end
            step();
        end
        chk("beat_seen", found, 1);
    endtask

    initial begin
        int base;
        beat_t e;
        for (int i = 0; i < 16; i++) begin
            mem[i]    = mass_word_t'(100 + i);
            tbl_m1[i] = '0;
            tbl_m2[i] = '0;
        end
        reset = 1'b1; start = 1'b0; num_links = '0;
        beat_if.out_ready = 1'b1;
        snoop_we = 1'b0; snoop_w_addr = '0; snoop_d = '0;
        repeat (3) step();
        chk("rst_out_valid", beat_if.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_link_addr", link_addr, 0);
        chk("rst_r_addr_q1", r_addr_q1, 0);
        chk("rst_r_addr_q2", r_addr_q2, 0);
        chk("rst_out_p1", beat_if.out_p1, 0);
        chk("rst_out_link", beat_if.out_link, 0);
        reset = 1'b0;
        step();

        // Clean three-link frame, no stalls: beats back to back, done right after the last.
        std_frame();
        pulse_start(3);
        chk("clean_busy", busy, 1);
        wait_done(40);
        chk("clean_done_time", done_cyc, start_cyc + 6);
        chk("clean_done_after_beat", done_cyc, last_hs_cyc + 1);
        chk("clean_queue_empty", exp_q.size(), 0);
        step();
        chk("clean_done_pulse", done, 0);
        chk("clean_busy_after", busy, 0);

        // Backpressure on beat 1, with a start attempt while busy.
        std_frame();
        pulse_start(3);
        wait_beat(1);
        beat_if.out_ready = 1'b0;
        num_links = 5'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("bp_held_valid", beat_if.out_valid, 1);
        chk("bp_held_link", beat_if.out_link, 1);
        beat_if.out_ready = 1'b1;
        wait_done(40);
        chk("bp_queue_empty", exp_q.size(), 0);
        step();

        // Zero-link frame.
        base = done_cnt;
        pulse_start(0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_valid", beat_if.out_valid, 0);
        step();
        chk("zero_done_pulse", done, 0);
        chk("zero_done_count", done_cnt - base, 1);

        // Reset while beat 1 is held.
        std_frame();
        pulse_start(3);
        wait_beat(1);
        beat_if.out_ready = 1'b0;
        step();
        base = done_cnt;
        reset = 1'b1;
        step();
        chk("mrst_valid", beat_if.out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        reset = 1'b0;
        exp_q.delete();
        beat_if.out_ready = 1'b1;
        repeat (4) step();
        chk("mrst_no_done", done_cnt - base, 0);
        std_frame();
        pulse_start(3);
        wait_done(40);
        chk("mrst_rerun_empty", exp_q.size(), 0);
        step();

        // Full 16-link frame with random backpressure.
        for (int i = 0; i < 16; i++) set_link(i, i, 15 - i);
        pulse_start(16);
        base = done_cnt;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != base) break;
            beat_if.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("full_done_seen", done_cnt - base, 1);
        chk("full_queue_empty", exp_q.size(), 0);
        beat_if.out_ready = 1'b1;
        step();

        // Same-cycle write to the address being read by the output stage.
        tbl_m1[0] = 4'd2;
        tbl_m2[0] = 4'd3;
`ifdef LINK_FETCH_FWD_EN
        e.p1 = mass_word_t'(999);
`else
        e.p1 = mass_word_t'(102);
`endif
        e.p2   = mass_word_t'(103);
        e.link = 4'd0;
        exp_q.push_back(e);
        pulse_start(1);
        step();
        chk("fwd_r_addr", r_addr_q1, 2);
        snoop_we = 1'b1; snoop_w_addr = 4'd2; snoop_d = mass_word_t'(999);
        step();
        snoop_we = 1'b0;
        chk("fwd_valid", beat_if.out_valid, 1);
        wait_done(20);
        chk("fwd_queue_empty", exp_q.size(), 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
